// File: rtl/ddr_oiod_delay_ctrl.sv
// Output-delay-line controller for a group of DDR PHY output IODs.
// It accepts one per-lane tap request at a time and walks that lane's IOD
// delay line one tap per MOVE pulse. Each MOVE or LOAD pulse is followed by
// a settle gap. It keeps a shadow copy of every lane's current tap.
module ddr_oiod_delay_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2,
  parameter int TAP_W     = 8,
  parameter int MAX_TAP   = 255,
  parameter int INIT_TAP  = 1,
  parameter int MOVE_GAP  = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [LANE_W-1:0]          REQ_LANE,
  input  logic [TAP_W-1:0]           REQ_TAP,
  input  logic                       REQ_LOAD,
  output logic                       DONE,
  output logic [LANE_W-1:0]          DONE_LANE,
  output logic                       DONE_ERR,
  output logic [NUM_LANES*TAP_W-1:0] CUR_TAP,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);

  localparam int GAP_W = $clog2(MOVE_GAP + 1);
  localparam logic [LANE_W:0]    NUM_LANES_X = (LANE_W + 1)'(NUM_LANES);
  localparam logic [TAP_W:0]     MAX_TAP_X   = (TAP_W + 1)'(MAX_TAP);
  localparam logic [TAP_W-1:0]   INIT_T      = TAP_W'(INIT_TAP);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(MOVE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIR, S_STEP, S_LOAD, S_GAP, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [LANE_W-1:0]  lane_reg;
  logic [TAP_W-1:0]   target_reg;
  logic               load_reg;
  logic               err_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [TAP_W-1:0]   prev_tap_reg;
  logic [TAP_W-1:0]   cur_tap_reg [NUM_LANES];
  logic [NUM_LANES-1:0] dir_reg;

  logic [NUM_LANES-1:0] lane_sel;
  logic [TAP_W-1:0]     req_cur;
  logic [TAP_W-1:0]     sel_cur;
  logic                 oor_sel;
  logic                 req_reject;

  // Decode the latched lane into a one-hot select and gate the outputs per lane.
  // Reset masks everything immediately, so an aborted operation drops its
  // pulses in the same cycle the reset arrives.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_sel[gi]             = (lane_reg == LANE_W'(gi));
    assign DELAY_LINE_MOVE[gi]      = !SYNC_RST && (state_reg == S_STEP) && lane_sel[gi];
    assign DELAY_LINE_LOAD[gi]      = !SYNC_RST && (state_reg == S_LOAD) && lane_sel[gi];
    assign DELAY_LINE_DIRECTION[gi] = !SYNC_RST && dir_reg[gi];
    assign CUR_TAP[gi*TAP_W +: TAP_W] = SYNC_RST ? INIT_T : cur_tap_reg[gi];
  end

  // Look up the current tap of the requested lane and of the latched lane,
  // and pick out the latched lane's range flag.
  always_comb begin
    req_cur = '0;
    sel_cur = '0;
    oor_sel = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (REQ_LANE == LANE_W'(i)) req_cur = cur_tap_reg[i];
      if (lane_sel[i]) begin
        sel_cur = cur_tap_reg[i];
        oor_sel = DELAY_LINE_OUT_OF_RANGE[i];
      end
    end
  end

  assign req_reject = ({1'b0, REQ_LANE} >= NUM_LANES_X) ||
                      (!REQ_LOAD && ({1'b0, REQ_TAP} > MAX_TAP_X));

  assign REQ_READY = !SYNC_RST && (state_reg == S_IDLE);
  assign DONE      = !SYNC_RST && (state_reg == S_DONE);
  assign DONE_LANE = DONE ? lane_reg : '0;
  assign DONE_ERR  = DONE && err_reg;

  // State register.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: request dispatch, per-step sequencing and gap exit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (REQ_VALID) begin
          if (req_reject)          state_next = S_DONE;
          else if (REQ_LOAD)       state_next = S_LOAD;
          else if (REQ_TAP == req_cur) state_next = S_DONE;
          else                     state_next = S_DIR;
        end
      end
      S_DIR:  state_next = S_STEP;
      S_STEP: state_next = S_GAP;
      S_LOAD: state_next = S_GAP;
      S_GAP: begin
        // A range flag wins over normal completion, even on the last gap cycle.
        if (oor_sel) state_next = S_DONE;
        else if (gap_cnt_reg == '0) begin
          if (load_reg || (sel_cur == target_reg)) state_next = S_DONE;
          else                                     state_next = S_DIR;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, settle counter and error flag.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      lane_reg     <= '0;
      target_reg   <= '0;
      load_reg     <= 1'b0;
      err_reg      <= 1'b0;
      gap_cnt_reg  <= '0;
      prev_tap_reg <= INIT_T;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (REQ_VALID) begin
            lane_reg   <= REQ_LANE;
            target_reg <= REQ_TAP;
            load_reg   <= REQ_LOAD;
            err_reg    <= req_reject;
          end
        end
        S_STEP, S_LOAD: begin
          prev_tap_reg <= sel_cur;
          gap_cnt_reg  <= GAP_LAST;
        end
        S_GAP: begin
          if (oor_sel)                err_reg     <= 1'b1;
          else if (gap_cnt_reg != '0) gap_cnt_reg <= gap_cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-lane shadow tap and direction: step on MOVE, reload on LOAD,
  // roll back the last move when the IOD flags out-of-range.
  always_ff @(posedge FAB_CLK) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (SYNC_RST) begin
        cur_tap_reg[i] <= INIT_T;
        dir_reg[i]     <= 1'b0;
      end else if (lane_sel[i]) begin
        case (state_reg)
          S_DIR:  dir_reg[i] <= (target_reg > cur_tap_reg[i]);
          S_STEP: cur_tap_reg[i] <= dir_reg[i] ? cur_tap_reg[i] + 1'b1
                                                : cur_tap_reg[i] - 1'b1;
          S_LOAD: cur_tap_reg[i] <= INIT_T;
          S_GAP:  if (oor_sel) cur_tap_reg[i] <= prev_tap_reg;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_oiod_delay_ctrl.sv
// Directed bench for ddr_oiod_delay_ctrl. Each test task issues requests
// and compares the outcome against hand-computed cycle counts and tap values.
module tb_ddr_oiod_delay_ctrl;

  localparam int NL = 4;
  localparam int LW = 3;
  localparam int TW = 9;
  localparam int GAP = 4;

  logic            clk = 1'b0;
  logic            srst;
  logic            req_valid;
  logic            req_ready;
  logic [LW-1:0]   req_lane;
  logic [TW-1:0]   req_tap;
  logic            req_load;
  logic            done;
  logic [LW-1:0]   done_lane;
  logic            done_err;
  logic [NL*TW-1:0] cur_tap;
  logic [NL-1:0]   dl_move, dl_dir, dl_load, dl_oor;

  int checks = 0;
  int failures = 0;

  int            obs_done_cyc;
  logic          obs_err;
  logic [LW-1:0] obs_lane;
  int            obs_moves [NL];
  int            obs_loads [NL];
  int            obs_load_cyc;
  int            obs_multi;
  int            obs_ready_bad;
  int            obs_wait;

  always #5 clk = ~clk;

  ddr_oiod_delay_ctrl #(
    .NUM_LANES(NL), .LANE_W(LW), .TAP_W(TW),
    .MAX_TAP(255), .INIT_TAP(1), .MOVE_GAP(GAP)
  ) dut (
    .FAB_CLK(clk),
    .SYNC_RST(srst),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_LANE(req_lane),
    .REQ_TAP(req_tap),
    .REQ_LOAD(req_load),
    .DONE(done),
    .DONE_LANE(done_lane),
    .DONE_ERR(done_err),
    .CUR_TAP(cur_tap),
    .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir),
    .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor)
  );

  function automatic logic [TW-1:0] cur(input int l);
    return cur_tap[l*TW +: TW];
  endfunction

  // Issue one request and record what the DUT does until DONE (bounded).
  // oor_cyc: cycle in which the range flag of the target lane is raised.
  // hold: keep REQ_VALID high with a different request while busy.
  task automatic run_req(input logic [LW-1:0] lane, input logic [TW-1:0] tap,
                         input logic ld, input int oor_cyc, input bit hold);
    obs_done_cyc = -1; obs_err = 1'bx; obs_lane = 'x; obs_load_cyc = -1;
    obs_multi = 0; obs_ready_bad = 0; obs_wait = 0;
    for (int i = 0; i < NL; i++) begin obs_moves[i] = 0; obs_loads[i] = 0; end
    @(negedge clk);
    req_valid = 1'b1; req_lane = lane; req_tap = tap; req_load = ld;
    while (req_ready !== 1'b1 && obs_wait < 50) begin
      @(negedge clk);
      obs_wait++;
    end
    @(posedge clk);
    #1;
    if (hold) begin req_lane = '0; req_tap = 9'd9; req_load = 1'b0; end
    else req_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        if (dl_move[i]) obs_moves[i]++;
        if (dl_load[i]) begin
          obs_loads[i]++;
          if (obs_load_cyc < 0) obs_load_cyc = c;
        end
      end
      if ($countones(dl_move | dl_load) > 1) obs_multi++;
      if (req_ready !== 1'b0) obs_ready_bad++;
      dl_oor = (c == oor_cyc) ? (4'b0001 << lane) : 4'b0000;
      if (done === 1'b1) begin
        obs_done_cyc = c; obs_err = done_err; obs_lane = done_lane;
        req_valid = 1'b0; dl_oor = '0;
        break;
      end
    end
    $display("req lane=%0d tap=%0d load=%0d -> done_cyc=%0d err=%0d moves=%0d/%0d/%0d/%0d",
             lane, tap, ld, obs_done_cyc, obs_err,
             obs_moves[0], obs_moves[1], obs_moves[2], obs_moves[3]);
  endtask

  task automatic test_reset;
    srst = 1'b1; req_valid = 1'b0; req_lane = '0; req_tap = '0; req_load = 1'b0; dl_oor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++;
    if ({done, done_err, done_lane, dl_move, dl_load, dl_dir} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {done, done_err, done_lane, dl_move, dl_load, dl_dir});
    end
    checks++;
    if (cur_tap !== {NL{9'd1}}) begin failures++; $display("FAIL reset_cur_tap got=%h exp=%h", cur_tap, {NL{9'd1}}); end
    srst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", req_ready); end
    $display("reset done");
  endtask

  task automatic test_increment;
    run_req(3'd2, 9'd4, 1'b0, -1, 1'b0);
    checks++;
    if (obs_done_cyc !== 19) begin failures++; $display("FAIL inc_done_cyc got=%0d exp=19", obs_done_cyc); end
    checks++;
    if (obs_err !== 1'b0 || obs_lane !== 3'd2) begin failures++; $display("FAIL inc_done_info got err=%b lane=%0d exp err=0 lane=2", obs_err, obs_lane); end
    checks++;
    if (obs_moves[2] !== 3 || obs_moves[0] + obs_moves[1] + obs_moves[3] !== 0) begin
      failures++; $display("FAIL inc_moves got=%0d/%0d/%0d/%0d exp=0/0/3/0", obs_moves[0], obs_moves[1], obs_moves[2], obs_moves[3]);
    end
    checks++;
    if (dl_dir !== 4'b0100) begin failures++; $display("FAIL inc_dir got=%b exp=0100", dl_dir); end
    checks++;
    if (cur(2) !== 9'd4) begin failures++; $display("FAIL inc_cur got=%0d exp=4", cur(2)); end
    checks++;
    if (obs_ready_bad !== 0 || obs_multi !== 0) begin failures++; $display("FAIL inc_ready_multi got=%0d/%0d exp=0/0", obs_ready_bad, obs_multi); end
  endtask

  task automatic test_decrement_load;
    run_req(3'd0, 9'd4, 1'b0, -1, 1'b0);
    checks++;
    if (obs_done_cyc !== 19 || cur(0) !== 9'd4 || dl_dir !== 4'b0101) begin
      failures++; $display("FAIL dec_setup got cyc=%0d cur=%0d dir=%b exp cyc=19 cur=4 dir=0101", obs_done_cyc, cur(0), dl_dir);
    end
    run_req(3'd0, 9'd0, 1'b0, -1, 1'b0);
    checks++;
    if (obs_wait !== 0) begin failures++; $display("FAIL back_to_back_wait got=%0d exp=0", obs_wait); end
    checks++;
    if (obs_done_cyc !== 25 || obs_moves[0] !== 4 || obs_err !== 1'b0) begin
      failures++; $display("FAIL dec_run got cyc=%0d moves=%0d err=%b exp cyc=25 moves=4 err=0", obs_done_cyc, obs_moves[0], obs_err);
    end
    checks++;
    if (cur(0) !== 9'd0 || dl_dir !== 4'b0100) begin failures++; $display("FAIL dec_final got cur=%0d dir=%b exp cur=0 dir=0100", cur(0), dl_dir); end
    run_req(3'd0, 9'd77, 1'b1, -1, 1'b0);
    checks++;
    if (obs_load_cyc !== 1 || obs_loads[0] !== 1 || obs_done_cyc !== 6) begin
      failures++; $display("FAIL load_timing got load_cyc=%0d loads=%0d done=%0d exp 1/1/6", obs_load_cyc, obs_loads[0], obs_done_cyc);
    end
    checks++;
    if (cur(0) !== 9'd1 || obs_err !== 1'b0 || obs_moves[0] !== 0) begin
      failures++; $display("FAIL load_result got cur=%0d err=%b moves=%0d exp cur=1 err=0 moves=0", cur(0), obs_err, obs_moves[0]);
    end
    run_req(3'd0, 9'd1, 1'b0, -1, 1'b0);
    checks++;
    if (obs_done_cyc !== 1 || obs_err !== 1'b0 || obs_moves[0] !== 0) begin
      failures++; $display("FAIL zero_move got cyc=%0d err=%b moves=%0d exp 1/0/0", obs_done_cyc, obs_err, obs_moves[0]);
    end
  endtask

  task automatic test_reject;
    run_req(3'd1, 9'd256, 1'b0, -1, 1'b0);
    checks++;
    if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_lane !== 3'd1) begin
      failures++; $display("FAIL reject_tap got cyc=%0d err=%b lane=%0d exp 1/1/1", obs_done_cyc, obs_err, obs_lane);
    end
    checks++;
    if (obs_moves[1] + obs_loads[1] !== 0 || cur(1) !== 9'd1) begin
      failures++; $display("FAIL reject_tap_pulses got pulses=%0d cur=%0d exp 0/1", obs_moves[1] + obs_loads[1], cur(1));
    end
    run_req(3'd5, 9'd3, 1'b0, -1, 1'b0);
    checks++;
    if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_lane !== 3'd5) begin
      failures++; $display("FAIL reject_lane got cyc=%0d err=%b lane=%0d exp 1/1/5", obs_done_cyc, obs_err, obs_lane);
    end
    run_req(3'd5, 9'd0, 1'b1, -1, 1'b0);
    checks++;
    if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_load_cyc !== -1) begin
      failures++; $display("FAIL reject_lane_load got cyc=%0d err=%b load_cyc=%0d exp 1/1/-1", obs_done_cyc, obs_err, obs_load_cyc);
    end
  endtask

  task automatic test_out_of_range;
    // 1 -> 6 on lane 1: second MOVE in cycle 8, its gap is cycles 9..12.
    run_req(3'd1, 9'd6, 1'b0, 10, 1'b0);
    checks++;
    if (obs_done_cyc !== 11 || obs_err !== 1'b1 || obs_lane !== 3'd1) begin
      failures++; $display("FAIL oor_done got cyc=%0d err=%b lane=%0d exp 11/1/1", obs_done_cyc, obs_err, obs_lane);
    end
    checks++;
    if (cur(1) !== 9'd2 || obs_moves[1] !== 2) begin
      failures++; $display("FAIL oor_restore got cur=%0d moves=%0d exp 2/2", cur(1), obs_moves[1]);
    end
  endtask

  task automatic test_busy_ignored;
    run_req(3'd3, 9'd3, 1'b0, -1, 1'b1);
    checks++;
    if (obs_done_cyc !== 13 || cur(3) !== 9'd3 || obs_ready_bad !== 0) begin
      failures++; $display("FAIL busy_run got cyc=%0d cur=%0d ready_bad=%0d exp 13/3/0", obs_done_cyc, cur(3), obs_ready_bad);
    end
    checks++;
    if (obs_moves[0] !== 0 || cur(0) !== 9'd1) begin
      failures++; $display("FAIL busy_ignored got moves0=%0d cur0=%0d exp 0/1", obs_moves[0], cur(0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || cur(0) !== 9'd1 || dl_dir !== 4'b1110) begin
      failures++; $display("FAIL busy_after got ready=%b done=%b cur0=%0d dir=%b exp 1/0/1/1110", req_ready, done, cur(0), dl_dir);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    @(negedge clk);
    req_valid = 1'b1; req_lane = 3'd3; req_tap = 9'd60; req_load = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dl_move !== 4'b1000) begin failures++; $display("FAIL mid_move got=%b exp=1000", dl_move); end
    @(negedge clk);
    srst = 1'b1;
    #1;
    checks++;
    if (dl_move !== 4'b0 || dl_load !== 4'b0 || cur(3) !== 9'd1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset got move=%b load=%b cur3=%0d ready=%b exp 0/0/1/0", dl_move, dl_load, cur(3), req_ready);
    end
    repeat (2) @(negedge clk);
    srst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || dl_move !== 4'b0) dones++;
    end
    checks++;
    if (dones !== 0 || cur(3) !== 9'd1 || req_ready !== 1'b1) begin
      failures++; $display("FAIL mid_after got events=%0d cur3=%0d ready=%b exp 0/1/1", dones, cur(3), req_ready);
    end
    $display("reset mid-step lane=3 cur=%0d", cur(3));
  endtask

  initial begin
    test_reset;
    test_increment;
    test_decrement_load;
    test_reject;
    test_out_of_range;
    test_busy_ignored;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
